// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: word width, memory-access FSM states,
// and the access capture record used by the memory interface.
package lc3_pkg;

   localparam int          LC3_WORD_W    = 16;
   // Base of the memory-mapped I/O page, reserved for the I/O decoder.
   localparam logic [15:0] LC3_MMIO_BASE = 16'hFE00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_HOLD = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic [LC3_WORD_W-1:0] addr;
      logic [LC3_WORD_W-1:0] data;
      logic                  we;
   } mem_cap_t;

endpackage

// File: rtl/memory_interface_unit_fsm.sv
// Memory access handshake: captures address/data/direction at access start,
// holds them across the bus cycle, and reports completion (R) or timeout.
module mem_access_fsm
   import lc3_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mioEn_i,
   input  logic                  rw_i,
   input  logic [LC3_WORD_W-1:0] mar_i,
   input  logic [LC3_WORD_W-1:0] mdr_i,
   input  logic                  memReady_i,
   output logic                  memReq_o,
   output logic                  memWe_o,
   output logic [LC3_WORD_W-1:0] memAddr_o,
   output logic [LC3_WORD_W-1:0] memWData_o,
   output logic                  rdLoad_o,
   output logic                  R_o,
   output logic                  busy_o,
   output logic                  timeoutErr_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   mem_state_e       state_q, state_d;
   mem_cap_t         cap_q, cap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tout_q, tout_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cap_q   <= '0;
         cnt_q   <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cap_d    = cap_q;
      cnt_d    = cnt_q;
      tout_d   = tout_q;
      rdLoad_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // MAR/MDR are sampled pre-edge, so same-cycle loads are not seen.
            if (mioEn_i) begin
               cap_d   = '{addr: mar_i, data: mdr_i, we: rw_i};
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Completion outranks a timeout landing on the same edge.
            if (memReady_i) begin
               rdLoad_o = !cap_q.we;
               state_d  = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               tout_d  = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: state_d = mioEn_i ? ST_HOLD : ST_IDLE;
         ST_HOLD: if (!mioEn_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign memReq_o     = (state_q == ST_REQ);
   assign memWe_o      = memReq_o & cap_q.we;
   assign memAddr_o    = cap_q.addr;
   assign memWData_o   = cap_q.data;
   assign R_o          = (state_q == ST_DONE);
   assign busy_o       = (state_q != ST_IDLE);
   assign timeoutErr_o = tout_q;

endmodule

// File: rtl/memory_interface_unit.sv
// LC-3 memory interface: MAR/MDR registers with their bus/memory load muxes,
// wrapped around the memory access handshake FSM.
module memory_interface_unit
   import lc3_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LC3_WORD_W-1:0] Bus,
   input  logic                  ldMAR,
   input  logic                  ldMDR,
   input  logic                  mioEn,
   input  logic                  rw,
   output logic [LC3_WORD_W-1:0] MAROut,
   output logic [LC3_WORD_W-1:0] MDROut,
   output logic [LC3_WORD_W-1:0] memAddr,
   output logic [LC3_WORD_W-1:0] memWData,
   input  logic [LC3_WORD_W-1:0] memRData,
   output logic                  memReq,
   output logic                  memWe,
   input  logic                  memReady,
   output logic                  R,
   output logic                  busy,
   output logic                  timeoutErr
);

   logic [LC3_WORD_W-1:0] mar_q, mar_d;
   logic [LC3_WORD_W-1:0] mdr_q, mdr_d;
   logic                  rd_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mar_q <= '0;
         mdr_q <= '0;
      end else begin
         mar_q <= mar_d;
         mdr_q <= mdr_d;
      end
   end

   always_comb begin
      mar_d = ldMAR ? Bus : mar_q;
      mdr_d = mdr_q;
      // Read data wins over a bus load if mioEn was dropped mid-access.
      if (rd_load)
         mdr_d = memRData;
      else if (ldMDR && !mioEn)
         mdr_d = Bus;
   end

   mem_access_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .mioEn_i      (mioEn),
      .rw_i         (rw),
      .mar_i        (mar_q),
      .mdr_i        (mdr_q),
      .memReady_i   (memReady),
      .memReq_o     (memReq),
      .memWe_o      (memWe),
      .memAddr_o    (memAddr),
      .memWData_o   (memWData),
      .rdLoad_o     (rd_load),
      .R_o          (R),
      .busy_o       (busy),
      .timeoutErr_o (timeoutErr)
   );

   assign MAROut = mar_q;
   assign MDROut = mdr_q;

endmodule

// File: tb/tb_memory_interface_unit.sv
// Scoreboard bench for memory_interface_unit: each access pushes its expected
// outcome, which is popped and compared when R reports completion.
module tb_memory_interface_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] Bus = 16'h1234;
   logic        ldMAR = 1'b1, ldMDR = 1'b1, mioEn = 1'b0, rw = 1'b0;
   logic [15:0] MAROut, MDROut, memAddr, memWData;
   logic [15:0] memRData = 16'h0;
   logic        memReq, memWe, memReady = 1'b0, R, busy, timeoutErr;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] mdr;
      logic        we;
      logic        tout;
      int          reqs;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   reqs;
   bit   ok, stable;

   memory_interface_unit #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .Bus(Bus), .ldMAR(ldMAR), .ldMDR(ldMDR),
      .mioEn(mioEn), .rw(rw), .MAROut(MAROut), .MDROut(MDROut),
      .memAddr(memAddr), .memWData(memWData), .memRData(memRData),
      .memReq(memReq), .memWe(memWe), .memReady(memReady), .R(R),
      .busy(busy), .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives the memory side until R; reports REQ cycle count and whether the
   // memory-side outputs matched the scoreboard head on every REQ cycle.
   task automatic run_access(input int delay, input bit en,
                             output int n, output bit done, output bit stab);
      exp_t h;
      n = 0; done = 1'b0; stab = 1'b1;
      h = sb[0];
      for (int i = 0; i < 100; i++) begin
         if (R) begin
            done = 1'b1;
            break;
         end
         if (memReq) begin
            n++;
            if (memAddr !== h.addr || memWData !== h.wdata || memWe !== h.we)
               stab = 1'b0;
            memReady = en && (n > delay);
         end else begin
            memReady = 1'b0;
         end
         step();
      end
      memReady = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++;
      if ({MAROut, MDROut, memAddr, memWData, memReq, memWe, R, busy, timeoutErr} !== '0) begin
         errors++;
         $display("FAIL reset_state got MAR=%h MDR=%h addr=%h wd=%h req=%b we=%b R=%b busy=%b to=%b",
                  MAROut, MDROut, memAddr, memWData, memReq, memWe, R, busy, timeoutErr);
      end
      rst_n = 1'b1; ldMAR = 1'b0; ldMDR = 1'b0;
   endtask

   task automatic test_loads();
      Bus = 16'h3000; ldMAR = 1'b1;
      step();
      ldMAR = 1'b0;
      checks++;
      if (MAROut !== 16'h3000) begin
         errors++; $display("FAIL load_mar got %h exp 3000", MAROut);
      end
      Bus = 16'hBEEF; ldMDR = 1'b1;
      step();
      ldMDR = 1'b0;
      checks++;
      if (MDROut !== 16'hBEEF) begin
         errors++; $display("FAIL load_mdr got %h exp beef", MDROut);
      end
   endtask

   task automatic test_read_zero_wait();
      rw = 1'b0; memRData = 16'hA5A5; mioEn = 1'b1;
      sb.push_back('{addr: 16'h3000, wdata: 16'hBEEF, mdr: 16'hA5A5, we: 1'b0, tout: 1'b0, reqs: 1});
      step();
      run_access(0, 1'b1, reqs, ok, stable);
      e = sb.pop_front();
      checks++;
      if ({ok, reqs[7:0], stable, MDROut, timeoutErr} !== {1'b1, e.reqs[7:0], 1'b1, e.mdr, e.tout}) begin
         errors++;
         $display("FAIL read_zero_wait got done=%b reqs=%0d stable=%b mdr=%h to=%b exp reqs=%0d mdr=%h to=%b",
                  ok, reqs, stable, MDROut, timeoutErr, e.reqs, e.mdr, e.tout);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({memReq, R, busy} !== 3'b001) begin
            errors++; $display("FAIL read_hold cyc%0d got req/R/busy=%b%b%b exp 001", i, memReq, R, busy);
         end
      end
      mioEn = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL hold_release got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_write_wait();
      Bus = 16'h4000; ldMAR = 1'b1;
      step();
      Bus = 16'h00FF; ldMAR = 1'b0; ldMDR = 1'b1;
      step();
      ldMDR = 1'b0; rw = 1'b1; memRData = 16'hDEAD; mioEn = 1'b1;
      sb.push_back('{addr: 16'h4000, wdata: 16'h00FF, mdr: 16'h00FF, we: 1'b1, tout: 1'b0, reqs: 4});
      step();
      run_access(3, 1'b1, reqs, ok, stable);
      e = sb.pop_front();
      checks++;
      if ({ok, reqs[7:0], stable, MDROut, timeoutErr} !== {1'b1, e.reqs[7:0], 1'b1, e.mdr, e.tout}) begin
         errors++;
         $display("FAIL write_wait got done=%b reqs=%0d stable=%b mdr=%h to=%b exp reqs=%0d mdr=%h to=%b",
                  ok, reqs, stable, MDROut, timeoutErr, e.reqs, e.mdr, e.tout);
      end
      mioEn = 1'b0; rw = 1'b0;
      step();
      checks++;
      if ({R, busy, memReq, memWe, memAddr, memWData} !== {4'b0000, 16'h4000, 16'h00FF}) begin
         errors++;
         $display("FAIL write_after got R=%b busy=%b req=%b we=%b addr=%h wd=%h exp 0 0 0 0 4000 00ff",
                  R, busy, memReq, memWe, memAddr, memWData);
      end
   endtask

   task automatic test_simultaneous();
      Bus = 16'h1111; ldMAR = 1'b1;
      step();
      Bus = 16'h5555; mioEn = 1'b1; rw = 1'b0; memRData = 16'h7E57;
      sb.push_back('{addr: 16'h1111, wdata: 16'h00FF, mdr: 16'h7E57, we: 1'b0, tout: 1'b0, reqs: 1});
      step();
      ldMAR = 1'b0;
      checks++;
      if ({memAddr, MAROut} !== {16'h1111, 16'h5555}) begin
         errors++; $display("FAIL same_cycle_mar got addr=%h mar=%h exp 1111 5555", memAddr, MAROut);
      end
      run_access(0, 1'b1, reqs, ok, stable);
      e = sb.pop_front();
      checks++;
      if ({ok, reqs[7:0], stable, MDROut, timeoutErr} !== {1'b1, e.reqs[7:0], 1'b1, e.mdr, e.tout}) begin
         errors++;
         $display("FAIL same_cycle_access got done=%b reqs=%0d stable=%b mdr=%h to=%b exp reqs=%0d mdr=%h",
                  ok, reqs, stable, MDROut, timeoutErr, e.reqs, e.mdr);
      end
      mioEn = 1'b0;
      step();
   endtask

   task automatic test_ready_on_timeout();
      mioEn = 1'b1; rw = 1'b0; memRData = 16'hC0DE;
      sb.push_back('{addr: 16'h5555, wdata: 16'h7E57, mdr: 16'hC0DE, we: 1'b0, tout: 1'b0, reqs: T});
      step();
      mioEn = 1'b0;
      run_access(T - 1, 1'b1, reqs, ok, stable);
      e = sb.pop_front();
      checks++;
      if ({ok, reqs[7:0], stable, MDROut, timeoutErr} !== {1'b1, e.reqs[7:0], 1'b1, e.mdr, e.tout}) begin
         errors++;
         $display("FAIL ready_on_timeout got done=%b reqs=%0d stable=%b mdr=%h to=%b exp reqs=%0d mdr=%h to=0",
                  ok, reqs, stable, MDROut, timeoutErr, e.reqs, e.mdr);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL drop_mioen_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_timeout();
      mioEn = 1'b1; rw = 1'b0; memRData = 16'hFFFF;
      sb.push_back('{addr: 16'h5555, wdata: 16'hC0DE, mdr: 16'hC0DE, we: 1'b0, tout: 1'b1, reqs: T});
      step();
      run_access(0, 1'b0, reqs, ok, stable);
      e = sb.pop_front();
      checks++;
      if ({ok, reqs[7:0], stable, MDROut, timeoutErr} !== {1'b1, e.reqs[7:0], 1'b1, e.mdr, e.tout}) begin
         errors++;
         $display("FAIL timeout got done=%b reqs=%0d stable=%b mdr=%h to=%b exp reqs=%0d mdr=%h to=1",
                  ok, reqs, stable, MDROut, timeoutErr, e.reqs, e.mdr);
      end
      mioEn = 1'b0;
      repeat (3) step();
      checks++;
      if ({timeoutErr, busy} !== 2'b10) begin
         errors++; $display("FAIL timeout_sticky got to=%b busy=%b exp 1 0", timeoutErr, busy);
      end
   endtask

   task automatic test_reset_mid_access();
      mioEn = 1'b1;
      repeat (2) step();
      checks++;
      if (memReq !== 1'b1) begin
         errors++; $display("FAIL mid_access_req got %b exp 1", memReq);
      end
      #3 rst_n = 1'b0;
      #1;
      sb.delete();
      checks++;
      if ({memReq, memWe, R, busy, timeoutErr, MDROut, MAROut, memAddr} !== '0) begin
         errors++;
         $display("FAIL async_reset got req=%b we=%b R=%b busy=%b to=%b mdr=%h mar=%h addr=%h exp all 0",
                  memReq, memWe, R, busy, timeoutErr, MDROut, MAROut, memAddr);
      end
      step();
      rst_n = 1'b1; memRData = 16'h1357;
      sb.push_back('{addr: 16'h0000, wdata: 16'h0000, mdr: 16'h1357, we: 1'b0, tout: 1'b0, reqs: 1});
      step();
      run_access(0, 1'b1, reqs, ok, stable);
      e = sb.pop_front();
      checks++;
      if ({ok, reqs[7:0], stable, MDROut, timeoutErr} !== {1'b1, e.reqs[7:0], 1'b1, e.mdr, e.tout}) begin
         errors++;
         $display("FAIL fresh_access got done=%b reqs=%0d stable=%b mdr=%h to=%b exp reqs=%0d mdr=%h to=0",
                  ok, reqs, stable, MDROut, timeoutErr, e.reqs, e.mdr);
      end
      mioEn = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_loads();
      test_read_zero_wait();
      test_write_wait();
      test_simultaneous();
      test_ready_on_timeout();
      test_timeout();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
